// File: rtl/wb_daq_pkg.sv
// wb_daq_pkg: shared constants for the DAQ sample FIFO.
//   DAQ_DW      - sample word width in bits
//   DAQ_FIFO_AW - FIFO address width (depth = 2**DAQ_FIFO_AW)
//   DAQ_FIFO_LW - width of the level counter (one more bit than the pointers,
//                 so it can represent a completely full FIFO)
package wb_daq_pkg;

    localparam int unsigned DAQ_DW      = 32;
    localparam int unsigned DAQ_FIFO_AW = 4;
    localparam int unsigned DAQ_FIFO_LW = DAQ_FIFO_AW + 1;

endpackage

// File: rtl/wb_daq_fifo_if.sv
// wb_daq_fifo_if: bundle between the FIFO and its writer/reader.
//   master modport: the aggregation stage / Wishbone read path side
//     (drives flush, wr_en, data_in, rd_en and, with the watermark option,
//     wm_level; observes everything else)
//   slave modport:  the FIFO itself
// Optional feature macro: DAQ_FIFO_WATERMARK_EN adds wm_level and watermark.
interface wb_daq_fifo_if
    import wb_daq_pkg::*;
#(
    parameter int unsigned DW = DAQ_DW,
    parameter int unsigned AW = DAQ_FIFO_AW
) ();

    logic          flush;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
`ifdef DAQ_FIFO_WATERMARK_EN
    logic [AW:0]   wm_level;
    logic          watermark;

    modport master (
        output flush, wr_en, data_in, rd_en, wm_level,
        input  data_out, data_valid, full, empty, level, overflow, watermark
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, wm_level,
        output data_out, data_valid, full, empty, level, overflow, watermark
    );
`else
    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, data_valid, full, empty, level, overflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, data_valid, full, empty, level, overflow
    );
`endif

endinterface

// File: rtl/wb_daq_fifo_ram.sv
// wb_daq_fifo_ram: simple dual-port storage, DEPTH x DW, no reset.
//   clk    - write and read clock
//   we     - write enable; wdata stored at waddr
//   re     - read enable; mem[raddr] registered into rdata, else rdata holds
// A read and a write to the same address in one cycle return the old word.
module wb_daq_fifo_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wb_daq_fifo.sv
// wb_daq_fifo: synchronous FIFO buffering packed DAQ sample words for the host.
//   wb_clk - clock, rising edge
//   wb_rst - asynchronous active-high reset
//   bus    - wb_daq_fifo_if.slave: flush, wr_en/data_in (push), rd_en (pop),
//            data_out/data_valid (registered pop result, 1 clk latency),
//            full, empty, level, sticky overflow
// Optional feature macro: DAQ_FIFO_WATERMARK_EN adds a registered watermark
// output, set while level >= wm_level (wm_level of 0 disables it).
module wb_daq_fifo
    import wb_daq_pkg::*;
#(
    parameter int unsigned DW = DAQ_DW,
    parameter int unsigned AW = DAQ_FIFO_AW
) (
    input logic           wb_clk,
    input logic           wb_rst,
    wb_daq_fifo_if.slave  bus
);

    localparam int unsigned LW       = AW + 1;
    localparam int unsigned Depth    = 1 << AW;
    localparam logic [LW-1:0] DepthLvl = LW'(Depth);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          valid_q, valid_d;
    // Set by the first pop after reset; until then data_out reads as zero
    // because the RAM read register itself has no reset.
    logic          loaded_q, loaded_d;
    logic          full, empty, push, pop;
    logic [DW-1:0] ram_rdata;

    assign full  = (level_q == DepthLvl);
    assign empty = (level_q == '0);
    // At full a simultaneous pop frees the slot, so the push is still taken.
    assign push  = bus.wr_en & (~full | bus.rd_en) & ~bus.flush;
    assign pop   = bus.rd_en & ~empty & ~bus.flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        loaded_d   = loaded_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                valid_d  = 1'b1;
                loaded_d = 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (bus.wr_en && full && !bus.rd_en) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            loaded_q   <= loaded_d;
        end
    end

    wb_daq_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (wb_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .re    (pop),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign bus.data_out   = loaded_q ? ram_rdata : '0;
    assign bus.data_valid = valid_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;

`ifdef DAQ_FIFO_WATERMARK_EN
    logic watermark_q, watermark_d;

    // Judged on the post-update level so it tracks level without extra lag.
    always_comb begin
        watermark_d = (level_d >= bus.wm_level) && (bus.wm_level != '0);
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            watermark_q <= 1'b0;
        end else begin
            watermark_q <= watermark_d;
        end
    end

    assign bus.watermark = watermark_q;
`endif

endmodule

// File: tb/tb_wb_daq_fifo.sv
module tb_wb_daq_fifo;
    import wb_daq_pkg::*;

    localparam int Depth = 1 << DAQ_FIFO_AW;

    logic wb_clk = 1'b0;
    logic wb_rst;
    always #5 wb_clk = ~wb_clk;

    wb_daq_fifo_if bus ();

    wb_daq_fifo dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue plus the observable registers.
    logic [31:0] mq[$];
    logic [31:0] m_dout;
    logic        m_valid;
    logic        m_ovf;
    logic        m_wm;
    int          m_wm_level = 8;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        int          level;
        logic        valid;
        logic [31:0] dout;
        logic        empty;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_wm    = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic rd, input logic fl,
                              input logic [31:0] din);
        bit was_full;
        bit was_empty;
        bit do_pop;
        bit do_push;
        was_full  = (mq.size() == Depth);
        was_empty = (mq.size() == 0);
        if (fl) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            do_pop  = rd && !was_empty;
            do_push = wr && (!was_full || rd);
            m_valid = do_pop;
            if (do_pop) m_dout = mq.pop_front();
            if (do_push) mq.push_back(din);
            if (wr && was_full && !rd) m_ovf = 1'b1;
        end
        m_wm = (m_wm_level != 0) && (mq.size() >= m_wm_level);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"}, 32'(bus.level), 32'(mq.size()));
        chk({tag, ".full"}, 32'(bus.full), 32'(mq.size() == Depth));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".data_valid"}, 32'(bus.data_valid), 32'(m_valid));
        chk({tag, ".data_out"}, bus.data_out, m_dout);
`ifdef DAQ_FIFO_WATERMARK_EN
        chk({tag, ".watermark"}, 32'(bus.watermark), 32'(m_wm));
`endif
    endtask

    // Apply one cycle of inputs at the negedge, advance the model at the
    // posedge, compare at the following negedge, then return inputs to idle.
    task automatic drive(input logic wr, input logic rd, input logic fl,
                         input logic [31:0] din, input string tag);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.flush   = fl;
        bus.data_in = din;
        @(posedge wb_clk);
        model_step(wr, rd, fl, din);
        @(negedge wb_clk);
        check_model(tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last;

        vecs[0] = '{1'b1, 1'b0, 32'hA000_0001, 1, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'hA000_0002, 2, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'hA000_0003, 3, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0,         2, 1'b1, 32'hA000_0001, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0,         1, 1'b1, 32'hA000_0002, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0,         0, 1'b1, 32'hA000_0003, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h0,         0, 1'b0, 32'hA000_0003, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 32'h1234_5678, 1, 1'b0, 32'hA000_0003, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h1234_5678, 1'b1};

        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.data_in = '0;
`ifdef DAQ_FIFO_WATERMARK_EN
        bus.wm_level = 5'(m_wm_level);
`endif
        wb_rst = 1'b1;
        model_reset();
        #12;
        check_model("reset");
        @(negedge wb_clk);
        wb_rst = 1'b0;

        // Basic ordering, empty read and simultaneous access on empty.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.level", i), 32'(bus.level), 32'(vecs[i].level));
            chk($sformatf("vec%0d.valid", i), 32'(bus.data_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d.dout", i), bus.data_out, vecs[i].dout);
            chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vecs[i].empty));
        end

        // Fill to full, then a dropped 17th push.
        drive(1'b0, 1'b0, 1'b1, 32'h0, "fill.flush");
        for (int i = 0; i < Depth; i++) drive(1'b1, 1'b0, 1'b0, 32'hB000_0000 + 32'(i), "fill");
        chk("fill.full", 32'(bus.full), 32'd1);
        chk("fill.level16", 32'(bus.level), 32'd16);
        drive(1'b1, 1'b0, 1'b0, 32'hBBBB_BBBB, "ovf");
        chk("ovf.flag", 32'(bus.overflow), 32'd1);
        chk("ovf.level", 32'(bus.level), 32'd16);
        drive(1'b0, 1'b1, 1'b0, 32'h0, "ovf.pop");
        chk("ovf.first_word", bus.data_out, 32'hB000_0000);

        // Simultaneous push/pop at full.
        drive(1'b0, 1'b0, 1'b1, 32'h0, "both.flush");
        chk("both.ovf_cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < Depth; i++) drive(1'b1, 1'b0, 1'b0, 32'hC000_0000 + 32'(i), "both.fill");
        drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, "both");
        chk("both.level", 32'(bus.level), 32'd16);
        chk("both.no_ovf", 32'(bus.overflow), 32'd0);
        chk("both.popped", bus.data_out, 32'hC000_0000);
        last = '0;
        for (int i = 0; i < Depth; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, "both.drain");
            last = bus.data_out;
        end
        chk("both.sixteenth", last, 32'hDEAD_BEEF);
        chk("both.empty", 32'(bus.empty), 32'd1);

        // Pointer wrap followed by flush (with wr/rd asserted, both ignored).
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 32'hD000_0000 + 32'(i), "wrap.pre");
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 32'hD100_0000 + 32'(i), "wrap");
        chk("wrap.level5", 32'(bus.level), 32'd5);
        last = bus.data_out;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, "flush");
        chk("flush.level", 32'(bus.level), 32'd0);
        chk("flush.empty", 32'(bus.empty), 32'd1);
        chk("flush.dout_hold", bus.data_out, last);
        drive(1'b1, 1'b0, 1'b0, 32'hE000_0001, "post.push");
        drive(1'b0, 1'b1, 1'b0, 32'h0, "post.pop");
        chk("post.data", bus.data_out, 32'hE000_0001);

`ifdef DAQ_FIFO_WATERMARK_EN
        drive(1'b0, 1'b0, 1'b1, 32'h0, "wm.flush");
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 32'hF000_0000 + 32'(i), "wm.fill");
        chk("wm.below", 32'(bus.watermark), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'hF000_0007, "wm.eighth");
        chk("wm.reached", 32'(bus.watermark), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, "wm.pop");
        chk("wm.dropped", 32'(bus.watermark), 32'd0);
`endif

        // Randomized traffic: a fill-biased phase then a drain-biased phase.
        for (int i = 0; i < 400; i++) begin
            logic wr;
            logic rd;
            logic fl;
            wr = ($urandom_range(0, 99) < ((i < 200) ? 75 : 35));
            rd = ($urandom_range(0, 99) < ((i < 200) ? 35 : 70));
            fl = ($urandom_range(0, 99) < 2);
            drive(wr, rd, fl, $urandom, "rand");
        end

        // Asynchronous reset with data in flight.
        drive(1'b0, 1'b0, 1'b1, 32'h0, "rst.flush");
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 32'h9000_0000 + 32'(i), "rst.fill");
        drive(1'b0, 1'b1, 1'b0, 32'h0, "rst.pop");
        drive(1'b1, 1'b0, 1'b0, 32'h9000_0009, "rst.push");
        chk("rst.level9", 32'(bus.level), 32'd9);
        #2;
        wb_rst = 1'b1;
        #1;
        model_reset();
        check_model("rst.async");
        chk("rst.dout", bus.data_out, 32'h0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h7777_0001, "rst.after_push");
        drive(1'b0, 1'b1, 1'b0, 32'h0, "rst.after_pop");
        chk("rst.after_data", bus.data_out, 32'h7777_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
